// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared constants and helpers for the data-memory arbiter.
//   RAM_SIZE_DEF   : default data-memory depth in 32-bit words
//   STARVE_MAX_DEF : default number of CPU wins tolerated while DMA waits
//   CNT_W_DEF      : default starvation counter width
//   WORD_IDX_LSB   : lowest byte-address bit of the word index
//   DATA_W         : bus data/address width
//   in_range()     : true when a byte address maps to an existing word
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int RAM_SIZE_DEF   = 256;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W_DEF      = 4;
    localparam int WORD_IDX_LSB   = 2;
    localparam int DATA_W         = 32;

    function automatic logic in_range(input logic [DATA_W-1:0] addr,
                                      input int unsigned ram_size);
        logic [DATA_W-1:0] w_idx;
        w_idx = addr >> WORD_IDX_LSB;
        return (w_idx < ram_size);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arb_if
// Bundles the CPU MEM-stage port, the DMA port and the data-memory port.
//   slave  : arbiter view (takes CPU/DMA requests and mem_rdata, drives the rest)
//   master : environment view (CPU, DMA master and memory side)
// ---------------------------------------------------------------------------
interface dmem_arb_if;
    import dmem_arb_pkg::*;

    // CPU MEM stage
    logic              cpu_rd;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // DMA / peripheral master
    logic              dma_req;
    logic              dma_we;
    logic [DATA_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;
    logic              dma_err;

    // Data memory
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid, dma_err,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid, dma_err,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
// Counts cycles a pending DMA request has lost to the CPU, saturating at MAX.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : clear to zero (DMA granted or no DMA request)
//   i_inc      : DMA waited behind the CPU this cycle
//   o_sat      : counter has reached MAX, DMA must win now
// ---------------------------------------------------------------------------
module starve_counter #(
    parameter int CNT_W = 4,
    parameter int MAX   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_sat
);

    logic [CNT_W-1:0] r_cnt;

    assign o_sat = (r_cnt == CNT_W'(MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter in front of the single-port data memory. The CPU MEM
// stage passes through combinationally; a DMA master gets single-beat
// accesses with registered read return. A starvation counter forces the DMA
// through after STARVE_MAX lost cycles, stalling the CPU for that one cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_arb_if.slave (CPU port, DMA port, memory port)
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RAM_SIZE   = RAM_SIZE_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input logic        clk,
    input logic        reset,
    dmem_arb_if.slave  bus
);

    logic              w_cpu_req;
    logic              w_in_range;
    logic              w_sat;
    logic              w_dma_sel;
    logic              w_dma_rd_ok;

    logic              r_dma_rvalid;
    logic              r_dma_err;
    logic [DATA_W-1:0] r_dma_rdata;

    assign w_cpu_req   = bus.cpu_rd | bus.cpu_wr;
    assign w_in_range  = in_range(bus.dma_addr, RAM_SIZE);
    // DMA wins when the CPU is idle, or when it has already lost STARVE_MAX times
    assign w_dma_sel   = bus.dma_req & (~w_cpu_req | w_sat);
    assign w_dma_rd_ok = w_dma_sel & ~bus.dma_we & w_in_range;

    starve_counter #(
        .CNT_W (CNT_W),
        .MAX   (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_dma_sel | ~bus.dma_req),
        .i_inc (bus.dma_req & w_cpu_req & ~w_dma_sel),
        .o_sat (w_sat)
    );

    // Grant mux: everything defaults to 0 so an idle bus carries no stale values
    always_comb begin
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cpu_rdata = '0;
        bus.cpu_stall = 1'b0;
        bus.dma_gnt   = 1'b0;
        if (w_dma_sel) begin
            // Out-of-range DMA still gets a grant but touches nothing
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
            bus.mem_wr    = bus.dma_we & w_in_range;
            bus.mem_rd    = ~bus.dma_we & w_in_range;
            bus.cpu_stall = w_cpu_req;
            bus.dma_gnt   = 1'b1;
        end else begin
            bus.cpu_rdata = bus.mem_rdata;
            if (w_cpu_req) begin
                bus.mem_rd    = bus.cpu_rd;
                bus.mem_wr    = bus.cpu_wr;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
            end
        end
    end

    // DMA return stage: read data and error flag appear one cycle after grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dma_rvalid <= 1'b0;
            r_dma_err    <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_dma_rvalid <= w_dma_rd_ok;
            r_dma_err    <= w_dma_sel & ~w_in_range;
            if (w_dma_rd_ok) begin
                r_dma_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.dma_rvalid = r_dma_rvalid;
    assign bus.dma_err    = r_dma_err;
    assign bus.dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios plus randomized CPU/DMA traffic checked against a
// behavioural model (word-array shadow memory and a wait count per DMA
// request). A simple word-addressed RAM sits on the memory port.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int SMAX = 4;
    localparam int RSZ  = 256;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dmem_arb_if bus();

    dmem_arbiter #(
        .RAM_SIZE   (RSZ),
        .STARVE_MAX (SMAX),
        .CNT_W      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on clock edge, ignores out-of-range
    logic [31:0] ram [0:255] = '{default: 32'h0};
    logic [29:0] mem_idx;
    assign mem_idx       = bus.mem_addr[31:2];
    assign bus.mem_rdata = (bus.mem_rd && mem_idx < 30'd256) ? ram[mem_idx[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (bus.mem_wr && mem_idx < 30'd256) ram[mem_idx[7:0]] <= bus.mem_wdata;
    end

    // Expected memory contents
    logic [31:0] shadow [0:255];

    task automatic idle_inputs();
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        next(); next(); next();
        #2;
        checks++; if (bus.dma_rvalid !== 1'b0 || bus.dma_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: rvalid=%b err=%b want 0 0", bus.dma_rvalid, bus.dma_err); end
        checks++; if (bus.dma_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", bus.dma_rdata); end
        checks++; if (bus.dma_gnt !== 1'b0 || bus.cpu_stall !== 1'b0) begin
            errors++; $display("FAIL reset_gnt_stall: gnt=%b stall=%b want 0 0", bus.dma_gnt, bus.cpu_stall); end
        reset = 0;
    endtask

    task automatic test_dma_only();
        next();
        idle_inputs();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h10; bus.dma_wdata = 32'hDEADBEEF;
        #2;
        checks++; if (bus.dma_gnt !== 1'b1 || bus.cpu_stall !== 1'b0) begin
            errors++; $display("FAIL dma_wr_gnt: gnt=%b stall=%b want 1 0", bus.dma_gnt, bus.cpu_stall); end
        checks++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 32'h10 || bus.mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL dma_wr_bus: wr=%b rd=%b addr=%h wd=%h want 1 0 10 deadbeef",
                                bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata); end
        shadow[4] = 32'hDEADBEEF;
        next();
        bus.dma_we = 0; bus.dma_wdata = 0;
        #2;
        checks++; if (bus.dma_gnt !== 1'b1 || bus.mem_rd !== 1'b1 || bus.cpu_stall !== 1'b0) begin
            errors++; $display("FAIL dma_rd_gnt: gnt=%b rd=%b stall=%b want 1 1 0", bus.dma_gnt, bus.mem_rd, bus.cpu_stall); end
        checks++; if (bus.dma_rvalid !== 1'b0) begin
            errors++; $display("FAIL dma_wr_no_rvalid: got %b want 0", bus.dma_rvalid); end
        next();
        idle_inputs();
        #2;
        checks++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== shadow[4]) begin
            errors++; $display("FAIL dma_rd_return: rvalid=%b rdata=%h want 1 %h", bus.dma_rvalid, bus.dma_rdata, shadow[4]); end
        next();
        #2;
        checks++; if (bus.dma_rvalid !== 1'b0) begin
            errors++; $display("FAIL dma_rvalid_pulse: got %b want 0", bus.dma_rvalid); end
    endtask

    task automatic test_starve();
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i <= SMAX; i++) begin
                next();
                bus.cpu_rd = 1; bus.cpu_addr = 32'h10;
                bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h10;
                #2;
                checks++; if (bus.dma_gnt !== (i == SMAX) || bus.cpu_stall !== (i == SMAX)) begin
                    errors++; $display("FAIL starve_r%0d_c%0d: gnt=%b stall=%b want %b %b",
                                        round, i, bus.dma_gnt, bus.cpu_stall, i == SMAX, i == SMAX); end
                checks++; if (bus.cpu_rdata !== ((i == SMAX) ? 32'h0 : shadow[4])) begin
                    errors++; $display("FAIL starve_cpu_rdata_r%0d_c%0d: got %h", round, i, bus.cpu_rdata); end
            end
            next();
            bus.dma_req = 0;
            #2;
            checks++; if (bus.dma_gnt !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== shadow[4]) begin
                errors++; $display("FAIL starve_after_r%0d: gnt=%b stall=%b rdata=%h", round, bus.dma_gnt, bus.cpu_stall, bus.cpu_rdata); end
            checks++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== shadow[4]) begin
                errors++; $display("FAIL starve_return_r%0d: rvalid=%b rdata=%h", round, bus.dma_rvalid, bus.dma_rdata); end
        end
        idle_inputs();
    endtask

    task automatic test_withdraw();
        // DMA loses twice, withdraws one cycle, then must wait a full STARVE_MAX again
        for (int i = 0; i < 2; i++) begin
            next();
            bus.cpu_rd = 1; bus.cpu_addr = 32'h0; bus.dma_req = 1; bus.dma_addr = 32'h4;
        end
        next();
        bus.dma_req = 0;
        for (int i = 0; i <= SMAX; i++) begin
            next();
            bus.dma_req = 1;
            #2;
            checks++; if (bus.dma_gnt !== (i == SMAX)) begin
                errors++; $display("FAIL withdraw_c%0d: gnt=%b want %b", i, bus.dma_gnt, i == SMAX); end
        end
        next();
        idle_inputs();
    endtask

    task automatic test_collision();
        next();
        bus.cpu_wr = 1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h11111111;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h20; bus.dma_wdata = 32'h22222222;
        #2;
        checks++; if (bus.dma_gnt !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_wdata !== 32'h11111111) begin
            errors++; $display("FAIL collide_cpu_wins: gnt=%b stall=%b wd=%h", bus.dma_gnt, bus.cpu_stall, bus.mem_wdata); end
        shadow[8] = 32'h11111111;
        next();
        bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        #2;
        checks++; if (bus.dma_gnt !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_wdata !== 32'h22222222) begin
            errors++; $display("FAIL collide_dma_next: gnt=%b wr=%b wd=%h", bus.dma_gnt, bus.mem_wr, bus.mem_wdata); end
        shadow[8] = 32'h22222222;
        next();
        idle_inputs();
        bus.cpu_rd = 1; bus.cpu_addr = 32'h20;
        #2;
        checks++; if (bus.cpu_rdata !== shadow[8]) begin
            errors++; $display("FAIL collide_readback: got %h want %h", bus.cpu_rdata, shadow[8]); end
        next();
        idle_inputs();
    endtask

    task automatic test_oob();
        logic [31:0] held;
        held = bus.dma_rdata;
        next();
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h400;
        #2;
        checks++; if (bus.dma_gnt !== 1'b1 || bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
            errors++; $display("FAIL oob_rd_gnt: gnt=%b rd=%b wr=%b want 1 0 0", bus.dma_gnt, bus.mem_rd, bus.mem_wr); end
        next();
        bus.dma_we = 1; bus.dma_wdata = 32'hA5A5A5A5;
        #2;
        checks++; if (bus.dma_err !== 1'b1 || bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== held) begin
            errors++; $display("FAIL oob_rd_err: err=%b rvalid=%b rdata=%h want 1 0 %h", bus.dma_err, bus.dma_rvalid, bus.dma_rdata, held); end
        checks++; if (bus.dma_gnt !== 1'b1 || bus.mem_wr !== 1'b0) begin
            errors++; $display("FAIL oob_wr_gnt: gnt=%b wr=%b want 1 0", bus.dma_gnt, bus.mem_wr); end
        next();
        bus.dma_we = 0; bus.dma_addr = 32'h3FC; bus.dma_wdata = 0;
        #2;
        checks++; if (bus.dma_err !== 1'b1) begin
            errors++; $display("FAIL oob_wr_err: got %b want 1", bus.dma_err); end
        checks++; if (bus.mem_rd !== 1'b1) begin
            errors++; $display("FAIL last_word_rd: got %b want 1", bus.mem_rd); end
        next();
        idle_inputs();
        #2;
        checks++; if (bus.dma_err !== 1'b0 || bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== shadow[255]) begin
            errors++; $display("FAIL last_word_return: err=%b rvalid=%b rdata=%h", bus.dma_err, bus.dma_rvalid, bus.dma_rdata); end
    endtask

    task automatic test_reset_inflight();
        next();
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h10;
        next();
        idle_inputs();
        #2;
        checks++; if (bus.dma_rdata !== shadow[4]) begin
            errors++; $display("FAIL rst_pre_rdata: got %h want %h", bus.dma_rdata, shadow[4]); end
        next();
        reset = 1;
        bus.dma_req = 1; bus.dma_addr = 32'h10;
        #2;
        checks++; if (bus.dma_gnt !== 1'b1 || bus.mem_rd !== 1'b1) begin
            errors++; $display("FAIL rst_comb_follow: gnt=%b rd=%b want 1 1", bus.dma_gnt, bus.mem_rd); end
        next();
        reset = 0;
        idle_inputs();
        #2;
        checks++; if (bus.dma_rvalid !== 1'b0 || bus.dma_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_inflight: rvalid=%b rdata=%h want 0 0", bus.dma_rvalid, bus.dma_rdata); end
        // Build up a wait count, then reset over it
        for (int i = 0; i < 3; i++) begin
            next();
            reset = (i == 2);
            bus.cpu_rd = 1; bus.cpu_addr = 32'h0; bus.dma_req = 1; bus.dma_addr = 32'h8;
        end
        for (int i = 0; i <= SMAX; i++) begin
            next();
            reset = 0;
            #2;
            checks++; if (bus.dma_gnt !== (i == SMAX)) begin
                errors++; $display("FAIL rst_starve_c%0d: gnt=%b want %b", i, bus.dma_gnt, i == SMAX); end
        end
        next();
        idle_inputs();
    endtask

    task automatic test_idle();
        for (int n = 0; n < 20; n++) begin
            next();
            idle_inputs();
            bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
            bus.dma_addr = $urandom; bus.dma_wdata = $urandom; bus.dma_we = 1'($urandom);
            #2;
            checks++; if ({bus.mem_rd, bus.mem_wr, bus.cpu_stall, bus.dma_gnt} !== 4'b0 ||
                          bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
                errors++; $display("FAIL idle_c%0d: rd=%b wr=%b stall=%b gnt=%b addr=%h wd=%h", n,
                                    bus.mem_rd, bus.mem_wr, bus.cpu_stall, bus.dma_gnt, bus.mem_addr, bus.mem_wdata); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic        c_rd, c_wr, c_hold, d_act, d_we, sel, inr;
        logic [31:0] c_addr, c_wd, d_addr, d_wd, p_rdata;
        logic        p_rvalid, p_err;
        int          wait_n, r, w;
        c_rd = 0; c_wr = 0; c_hold = 0; d_act = 0; d_we = 0;
        c_addr = 0; c_wd = 0; d_addr = 0; d_wd = 0;
        p_rvalid = 0; p_err = 0; p_rdata = 0; wait_n = 0;
        next(); next();
        for (int n = 0; n < 400; n++) begin
            next();
            if (!c_hold) begin
                r = $urandom_range(0, 9);
                c_rd = (r < 4); c_wr = (r >= 4 && r < 7);
                c_addr = 32'($urandom_range(0, 15)) << 2; c_wd = $urandom;
            end
            if (!d_act) begin
                d_act = ($urandom_range(0, 1) == 1);
                d_we = 1'($urandom); d_wd = $urandom;
                r = $urandom_range(0, 19);
                w = (r < 16) ? r : (r == 16) ? 255 : (r == 17) ? 256 : (r == 18) ? 257 : 1000;
                d_addr = 32'(w) << 2;
            end
            bus.cpu_rd = c_rd; bus.cpu_wr = c_wr; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;
            bus.dma_req = d_act; bus.dma_we = d_we; bus.dma_addr = d_addr; bus.dma_wdata = d_wd;
            #2;
            sel = d_act && (!(c_rd || c_wr) || wait_n == SMAX);
            inr = (d_addr >> 2) < RSZ;
            checks++; if (bus.dma_gnt !== sel || bus.cpu_stall !== (sel && (c_rd || c_wr))) begin
                errors++; $display("FAIL rand_gnt_c%0d: gnt=%b stall=%b want %b %b", n,
                                    bus.dma_gnt, bus.cpu_stall, sel, sel && (c_rd || c_wr)); end
            if (!sel && c_rd) begin
                checks++; if (bus.cpu_rdata !== shadow[c_addr[9:2]]) begin
                    errors++; $display("FAIL rand_cpu_rd_c%0d: got %h want %h", n, bus.cpu_rdata, shadow[c_addr[9:2]]); end
            end
            checks++; if (bus.dma_rvalid !== p_rvalid || bus.dma_err !== p_err ||
                          (p_rvalid && bus.dma_rdata !== p_rdata)) begin
                errors++; $display("FAIL rand_ret_c%0d: rvalid=%b err=%b rdata=%h want %b %b %h", n,
                                    bus.dma_rvalid, bus.dma_err, bus.dma_rdata, p_rvalid, p_err, p_rdata); end
            // Advance the model by one clock
            p_rvalid = sel && !d_we && inr;
            p_err    = sel && !inr;
            if (p_rvalid) p_rdata = shadow[d_addr[9:2]];
            if (sel) begin
                if (d_we && inr) shadow[d_addr[9:2]] = d_wd;
                d_act  = 0;
                wait_n = 0;
            end else begin
                if (c_wr) shadow[c_addr[9:2]] = c_wd;
                wait_n = (d_act && (c_rd || c_wr)) ? ((wait_n < SMAX) ? wait_n + 1 : SMAX) : 0;
            end
            c_hold = sel && (c_rd || c_wr);
        end
        next();
        idle_inputs();
        next();
        for (int i = 0; i < 256; i++) begin
            if (i < 16 || i == 255) begin
                checks++; if (ram[i] !== shadow[i]) begin
                    errors++; $display("FAIL rand_mem_w%0d: got %h want %h", i, ram[i], shadow[i]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
        idle_inputs();
        test_reset();
        test_dma_only();
        test_starve();
        test_withdraw();
        test_collision();
        test_oob();
        test_reset_inflight();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
